// File: rtl/pipe_scheduler.sv
// pipe_scheduler: scrolls up to NUM_PIPES pipe obstacles per game tick, spawns new ones and
// sequences erase/draw requests to the shared pixel writer. Define PIPE_SCORE_EN for pass scoring.
module pipe_scheduler #(
  parameter int NUM_PIPES = 3,
  parameter int SCREEN_W  = 160,
  parameter int SPACING   = 56,
  parameter int Y_MIN     = 10,
  parameter int Y_MAX     = 90,
  parameter int BIRD_X    = 40
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       game_tick,
  input  logic       enable,
  input  logic [6:0] rand_y,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic       draw_erase,
  output logic       busy,
  output logic       tick_overrun,
  output logic       score_pulse,
  output logic [7:0] score
);

  localparam int IW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam logic [7:0] SPAWN_X = 8'(SCREEN_W - 1);

  typedef enum logic [2:0] {IDLE, SCAN, ERASE, MOVE, DRAW, SPAWN, SPAWN_DRAW} state_t;

  state_t               state_q, state_d;
  logic [7:0]           x_q [NUM_PIPES];
  logic [7:0]           x_d [NUM_PIPES];
  logic [6:0]           y_q [NUM_PIPES];
  logic [6:0]           y_d [NUM_PIPES];
  logic [NUM_PIPES-1:0] active_q, active_d;
  logic [IW:0]          idx_q, idx_d;
  logic [IW-1:0]        cur_q, cur_d, last_q, last_d;
  logic                 pending_q, pending_d;
  logic                 req_d, erase_d;
  logic [7:0]           dx_d;
  logic [6:0]           dy_d;
  logic                 tick_in, start, overrun_d;
  logic                 scan_found, free_found;
  logic [IW-1:0]        scan_idx, free_idx;
  logic [6:0]           clamped_y;
  logic [7:0]           move_x;
  logic                 spawn_ok, move_hit;

  // A tick landing while one is already pending is dropped; one landing as pending clears re-arms it.
  assign tick_in   = game_tick & enable;
  assign start     = (state_q == IDLE) & pending_q & enable;
  assign pending_d = tick_in | (pending_q & ~start);
  assign overrun_d = tick_in & pending_q & ~start;
  assign busy      = (state_q != IDLE);

  // Descending loops so the lowest qualifying index wins.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int k = NUM_PIPES - 1; k >= 0; k--) begin
      if (active_q[k] && ((IW+1)'(k) >= idx_q)) begin
        scan_found = 1'b1;
        scan_idx   = IW'(k);
      end
      if (!active_q[k]) begin
        free_found = 1'b1;
        free_idx   = IW'(k);
      end
    end
  end

  always_comb begin
    if (rand_y < 7'(Y_MIN))      clamped_y = 7'(Y_MIN);
    else if (rand_y > 7'(Y_MAX)) clamped_y = 7'(Y_MAX);
    else                         clamped_y = rand_y;
  end

  assign move_x   = (x_q[cur_q] == 8'd0) ? 8'd0 : x_q[cur_q] - 8'd1;
  assign move_hit = (state_q == MOVE) && (move_x == 8'(BIRD_X - 1));
  assign spawn_ok = free_found &&
                    (~|active_q || !active_q[last_q] || ((SPAWN_X - x_q[last_q]) >= 8'(SPACING)));

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    idx_d    = idx_q;
    cur_d    = cur_q;
    last_d   = last_q;
    req_d    = draw_req;
    dx_d     = draw_x;
    dy_d     = draw_y;
    erase_d  = draw_erase;
    for (int k = 0; k < NUM_PIPES; k++) begin
      x_d[k] = x_q[k];
      y_d[k] = y_q[k];
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (scan_found) begin
          cur_d   = scan_idx;
          req_d   = 1'b1;
          dx_d    = x_q[scan_idx];
          dy_d    = y_q[scan_idx];
          erase_d = 1'b1;
          state_d = ERASE;
        end else begin
          state_d = SPAWN;
        end
      end
      ERASE: begin
        if (draw_ack) begin
          req_d   = 1'b0;
          state_d = MOVE;
        end
      end
      MOVE: begin
        x_d[cur_q] = move_x;
        if (move_x == 8'd0) begin
          active_d[cur_q] = 1'b0;
          idx_d           = (IW+1)'(cur_q) + 1'b1;
          state_d         = SCAN;
        end else begin
          req_d   = 1'b1;
          dx_d    = move_x;
          erase_d = 1'b0;
          state_d = DRAW;
        end
      end
      DRAW: begin
        if (draw_ack) begin
          req_d   = 1'b0;
          idx_d   = (IW+1)'(cur_q) + 1'b1;
          state_d = SCAN;
        end
      end
      SPAWN: begin
        if (spawn_ok) begin
          x_d[free_idx]      = SPAWN_X;
          y_d[free_idx]      = clamped_y;
          active_d[free_idx] = 1'b1;
          last_d             = free_idx;
          req_d              = 1'b1;
          dx_d               = SPAWN_X;
          dy_d               = clamped_y;
          erase_d            = 1'b0;
          state_d            = SPAWN_DRAW;
        end else begin
          state_d = IDLE;
        end
      end
      SPAWN_DRAW: begin
        if (draw_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      active_q     <= '0;
      idx_q        <= '0;
      cur_q        <= '0;
      last_q       <= '0;
      pending_q    <= 1'b0;
      draw_req     <= 1'b0;
      draw_x       <= 8'd0;
      draw_y       <= 7'd0;
      draw_erase   <= 1'b0;
      tick_overrun <= 1'b0;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_q[k] <= 8'd0;
        y_q[k] <= 7'd0;
      end
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      idx_q        <= idx_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      pending_q    <= pending_d;
      draw_req     <= req_d;
      draw_x       <= dx_d;
      draw_y       <= dy_d;
      draw_erase   <= erase_d;
      tick_overrun <= overrun_d;
      for (int k = 0; k < NUM_PIPES; k++) begin
        x_q[k] <= x_d[k];
        y_q[k] <= y_d[k];
      end
    end
  end

`ifdef PIPE_SCORE_EN
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      score_pulse <= 1'b0;
      score       <= 8'd0;
    end else begin
      score_pulse <= move_hit;
      if (move_hit) score <= score + 8'd1;
    end
  end
`else
  logic score_unused;
  assign score_unused = move_hit;
  assign score_pulse  = 1'b0;
  assign score        = 8'd0;
`endif

endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: random ticks and ack timing against a slot-level reference model;
// expected requests are queued at tick time and a monitor compares every accepted handshake.
module tb_pipe_scheduler;

  localparam int NP       = 3;
  localparam int SCREEN_W = 160;
  localparam int SPACING  = 56;
  localparam int Y_MIN    = 10;
  localparam int Y_MAX    = 90;
  localparam int BIRD_X   = 40;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       game_tick = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] rand_y = 7'd0;
  logic       draw_ack = 1'b0;
  logic       draw_req, draw_erase, busy, tick_overrun, score_pulse;
  logic [7:0] draw_x, score;
  logic [6:0] draw_y;

  pipe_scheduler #(
    .NUM_PIPES(NP), .SCREEN_W(SCREEN_W), .SPACING(SPACING),
    .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .BIRD_X(BIRD_X)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .game_tick(game_tick), .enable(enable),
    .rand_y(rand_y), .draw_req(draw_req), .draw_ack(draw_ack), .draw_x(draw_x),
    .draw_y(draw_y), .draw_erase(draw_erase), .busy(busy), .tick_overrun(tick_overrun),
    .score_pulse(score_pulse), .score(score)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  int          m_x[NP];
  int          m_y[NP];
  bit          m_act[NP];
  int          m_last, m_score, m_pulses;
  int          overrun_seen = 0;
  int          pulse_seen = 0;
  bit          ack_en = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      m_x[k]   = 0;
      m_y[k]   = 0;
      m_act[k] = 1'b0;
    end
    m_last   = 0;
    m_score  = 0;
    m_pulses = 0;
    exp_q.delete();
  endtask

  // One frame of the game: every live pipe scrolls left one pixel, then maybe a new one appears.
  task automatic model_frame(input int ry);
    int free_k;
    bit any_act, gap_ok;
    int cy;
    for (int k = 0; k < NP; k++) begin
      if (m_act[k]) begin
        exp_q.push_back({1'b1, 7'(m_y[k]), 8'(m_x[k])});
        m_x[k] = m_x[k] - 1;
        if (m_x[k] == BIRD_X - 1) begin
          m_score = (m_score + 1) % 256;
          m_pulses++;
        end
        if (m_x[k] == 0) m_act[k] = 1'b0;
        else exp_q.push_back({1'b0, 7'(m_y[k]), 8'(m_x[k])});
      end
    end
    any_act = 1'b0;
    free_k  = -1;
    for (int k = 0; k < NP; k++) begin
      if (m_act[k]) any_act = 1'b1;
      else if (free_k < 0) free_k = k;
    end
    gap_ok = !any_act || !m_act[m_last] || ((SCREEN_W - 1 - m_x[m_last]) >= SPACING);
    if (gap_ok && free_k >= 0) begin
      cy = (ry < Y_MIN) ? Y_MIN : ((ry > Y_MAX) ? Y_MAX : ry);
      m_x[free_k]   = SCREEN_W - 1;
      m_y[free_k]   = cy;
      m_act[free_k] = 1'b1;
      m_last        = free_k;
      exp_q.push_back({1'b0, 7'(cy), 8'(SCREEN_W - 1)});
    end
  endtask

  task automatic pulse_tick(input logic [6:0] ry, input bit modelled);
    @(negedge CLOCK_50);
    rand_y    = ry;
    game_tick = 1'b1;
    if (modelled) model_frame(int'(ry));
    @(negedge CLOCK_50);
    game_tick = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 1000) begin
      @(negedge CLOCK_50);
      n++;
      if (busy) quiet = 0;
      else quiet++;
    end
    if (quiet < 3) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] ry);
    pulse_tick(ry, 1'b1);
    wait_idle();
  endtask

  task automatic wait_req(output int n);
    n = 1;
    while (!draw_req && n < 20) begin
      @(negedge CLOCK_50);
      n++;
    end
  endtask

  initial begin
    forever begin
      @(negedge CLOCK_50);
      draw_ack = ack_en && ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: every accepted request must match the oldest expectation.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge CLOCK_50);
      #1;
      if (resetn && draw_req && draw_ack) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("[TB] FAIL unexpected_req: got x=%0d y=%0d erase=%0b, expected no request",
                   draw_x, draw_y, draw_erase);
        end else begin
          e = exp_q.pop_front();
          check_output("req_fields", 32'({draw_erase, draw_y, draw_x}), 32'(e));
        end
      end
      if (tick_overrun) overrun_seen++;
      if (score_pulse) pulse_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, ov0;
    logic [7:0] sx;
    logic [6:0] sy;
    logic se;
    bit stable;
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    check_output("rst_draw_req", 32'(draw_req), 32'd0);
    check_output("rst_draw_x", 32'(draw_x), 32'd0);
    check_output("rst_draw_y", 32'(draw_y), 32'd0);
    check_output("rst_draw_erase", 32'(draw_erase), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_overrun", 32'(tick_overrun), 32'd0);
    check_output("rst_score_pulse", 32'(score_pulse), 32'd0);
    check_output("rst_score", 32'(score), 32'd0);
    resetn = 1'b1;
    enable = 1'b1;

    // First spawn: latency through SCAN and SPAWN, low rand_y clamps up
    pulse_tick(7'd5, 1'b1);
    wait_req(n);
    check_output("spawn_latency", 32'(n), 32'd4);
    check_output("spawn_fields", 32'({draw_erase, draw_y, draw_x}), 32'({1'b0, 7'd10, 8'd159}));
    ack_en = 1'b1;
    wait_idle();

    // Erase held without ack for 10 cycles
    ack_en = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    pulse_tick(7'($urandom_range(0, 127)), 1'b1);
    wait_req(n);
    check_output("erase_latency", 32'(n), 32'd3);
    sx = draw_x;
    sy = draw_y;
    se = draw_erase;
    check_output("hold_fields", 32'({se, sy, sx}), 32'(exp_q[0]));
    stable = 1'b1;
    repeat (10) begin
      @(negedge CLOCK_50);
      stable = stable && draw_req && (draw_x == sx) && (draw_y == sy) && (draw_erase == se);
    end
    check_output("hold_stable", 32'(stable), 32'd1);
    ack_en = 1'b1;
    wait_idle();

    // Long random run: multiple spawns, pipes reaching 0, slot reuse, pass detection
    for (int t = 0; t < 190; t++) apply_stimulus(7'($urandom_range(0, 127)));

    // Overrun: three ticks while the current frame is stalled
    ack_en = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    sy = 7'($urandom_range(0, 127));
    pulse_tick(sy, 1'b1);
    repeat (3) @(negedge CLOCK_50);
    ov0 = overrun_seen;
    pulse_tick(sy, 1'b1);
    pulse_tick(sy, 1'b0);
    pulse_tick(sy, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    check_output("overrun_pulses", 32'(overrun_seen - ov0), 32'd2);
    ack_en = 1'b1;
    wait_idle();
    check_output("queue_drained_1", 32'(exp_q.size()), 32'd0);

    // Ticks ignored while disabled
    enable = 1'b0;
    pulse_tick(7'd50, 1'b0);
    repeat (5) @(negedge CLOCK_50);
    check_output("disabled_busy", 32'(busy), 32'd0);
    check_output("disabled_req", 32'(draw_req), 32'd0);
    enable = 1'b1;

`ifdef PIPE_SCORE_EN
    check_output("score", 32'(score), 32'(m_score));
    check_output("score_pulses", 32'(pulse_seen), 32'(m_pulses));
`else
    check_output("score_off", 32'(score), 32'd0);
    check_output("score_pulse_off", 32'(pulse_seen), 32'd0);
`endif

    // Reset mid-erase with ack withheld
    ack_en = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    pulse_tick(7'($urandom_range(0, 127)), 1'b1);
    wait_req(n);
    check_output("pre_reset_req", 32'(draw_req), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_output("mid_reset_outputs",
                 32'({draw_req, draw_x, draw_y, draw_erase, busy, tick_overrun, score_pulse, score}),
                 32'd0);
    model_reset();
    pulse_seen = 0;
    @(negedge CLOCK_50);
    resetn = 1'b1;
    ack_en = 1'b1;
    apply_stimulus(7'd120);
    for (int t = 0; t < 60; t++) apply_stimulus(7'($urandom_range(0, 127)));
    check_output("queue_drained_2", 32'(exp_q.size()), 32'd0);
`ifdef PIPE_SCORE_EN
    check_output("score_after_reset", 32'(score), 32'(m_score));
`else
    check_output("score_off_after_reset", 32'(score), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
